// File: rtl/phy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : phy_pkg
// Brief    : Framing characters, idle word and state type shared by the PHY
//            transmit framer and the PHY receiver.
// Revision : 1.0 - initial release
// ============================================================================
package phy_pkg;

    localparam logic [7:0]  K28_5     = 8'hBC;
    localparam logic [7:0]  D16_2     = 8'h50;
    localparam logic [7:0]  SOF_K     = 8'hFB;
    localparam logic [7:0]  EOF_K     = 8'hFD;
    localparam logic [7:0]  PAD       = 8'h00;
    localparam logic [31:0] IDLE_WORD = 32'hBC50BC50;
    localparam logic [3:0]  IDLE_CHAR = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2
    } phy_state_t;

    // Valid byte count of a last beat: leading ones of keep, never below one.
    function automatic logic [2:0] lead_ones(input logic [3:0] keep);
        logic [2:0] n;
        if (keep == 4'b1111)           n = 3'd4;
        else if (keep[3:1] == 3'b111)  n = 3'd3;
        else if (keep[3:2] == 2'b11)   n = 3'd2;
        else                           n = 3'd1;
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phy_tx_framer_if.sv
`default_nettype none
// ============================================================================
// Module   : phy_tx_framer_if
// Brief    : 32-bit AXI-Stream payload bus feeding the PHY transmit framer.
// Revision : 1.0 - initial release
// ============================================================================
interface phy_tx_framer_if;

    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);

endinterface
`default_nettype wire

// File: rtl/phy_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : phy_tx_framer
// Brief    : Packs AXI-Stream frames into 4-byte GT TX words framed by
//            FB ... FD with a minimum run of comma idle words between frames.
// Revision : 1.0 - initial release
// ============================================================================
module phy_tx_framer
    import phy_pkg::*;
#(
    parameter int P_IDLE_GAP = 2
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst,
    phy_tx_framer_if.slave   axis,
    output logic [31:0]      o_gt_tx_data,
    output logic [3:0]       o_gt_tx_char
);

    localparam int C_GAP_W = $clog2(P_IDLE_GAP + 1);
    localparam logic [C_GAP_W-1:0] C_GAP_MAX = C_GAP_W'(P_IDLE_GAP);

    phy_state_t         state_q, state_d;
    logic [C_GAP_W-1:0] gap_q, gap_d, w_gap_inc;
    logic [7:0]         carry_q, carry_d;
    logic               carry_k_q, carry_k_d;
    logic [31:0]        tail_q, tail_d;
    logic [3:0]         tail_k_q, tail_k_d;
    logic               ready_q, ready_d;
    logic [31:0]        word_q, word_d;
    logic [3:0]         char_q, char_d;
    logic               w_accept;
    logic [2:0]         w_cnt;

    assign w_accept  = axis.tvalid & ready_q;
    assign w_cnt     = lead_ones(axis.tkeep);
    assign w_gap_inc = (gap_q == C_GAP_MAX) ? gap_q : gap_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        carry_d   = carry_q;
        carry_k_d = carry_k_q;
        tail_d    = tail_q;
        tail_k_d  = tail_k_q;
        ready_d   = ready_q;
        word_d    = IDLE_WORD;
        char_d    = IDLE_CHAR;
        case (state_q)
            ST_IDLE: begin
                gap_d = w_gap_inc;
                // The idle word emitted this cycle counts toward the gap.
                if (axis.tvalid && (w_gap_inc == C_GAP_MAX)) begin
                    state_d = ST_DATA;
                    ready_d = 1'b1;
                end
            end
            ST_DATA: begin
                if (!w_accept) begin
                    word_d = '0;
                    char_d = '0;
                end else if (!axis.tlast) begin
                    word_d    = {carry_q, axis.tdata[31:8]};
                    char_d    = {carry_k_q, 3'b000};
                    carry_d   = axis.tdata[7:0];
                    carry_k_d = 1'b0;
                end else begin
                    ready_d   = 1'b0;
                    carry_d   = SOF_K;
                    carry_k_d = 1'b1;
                    gap_d     = '0;
                    state_d   = ST_IDLE;
                    case (w_cnt)
                        3'd1: begin
                            word_d = {carry_q, axis.tdata[31:24], EOF_K, PAD};
                            char_d = {carry_k_q, 3'b010};
                        end
                        3'd2: begin
                            word_d = {carry_q, axis.tdata[31:16], EOF_K};
                            char_d = {carry_k_q, 3'b001};
                        end
                        3'd3: begin
                            word_d   = {carry_q, axis.tdata[31:8]};
                            char_d   = {carry_k_q, 3'b000};
                            tail_d   = {EOF_K, PAD, PAD, PAD};
                            tail_k_d = 4'b1000;
                            state_d  = ST_TAIL;
                        end
                        default: begin
                            word_d   = {carry_q, axis.tdata[31:8]};
                            char_d   = {carry_k_q, 3'b000};
                            tail_d   = {axis.tdata[7:0], EOF_K, PAD, PAD};
                            tail_k_d = 4'b0100;
                            state_d  = ST_TAIL;
                        end
                    endcase
                end
            end
            ST_TAIL: begin
                word_d  = tail_q;
                char_d  = tail_k_q;
                gap_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            gap_q     <= '0;
            carry_q   <= SOF_K;
            carry_k_q <= 1'b1;
            tail_q    <= '0;
            tail_k_q  <= '0;
            ready_q   <= 1'b0;
            word_q    <= IDLE_WORD;
            char_q    <= IDLE_CHAR;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            carry_q   <= carry_d;
            carry_k_q <= carry_k_d;
            tail_q    <= tail_d;
            tail_k_q  <= tail_k_d;
            ready_q   <= ready_d;
            word_q    <= word_d;
            char_q    <= char_d;
        end
    end

    // GT lane order: the first byte on the wire sits in byte 0.
    assign axis.tready  = ready_q;
    assign o_gt_tx_data = {word_q[7:0], word_q[15:8], word_q[23:16], word_q[31:24]};
    assign o_gt_tx_char = {char_q[0], char_q[1], char_q[2], char_q[3]};

endmodule
`default_nettype wire

// File: tb/tb_phy_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_phy_tx_framer
// Brief    : Self-checking bench: byte-stream framing model plus literal words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phy_tx_framer;
    import phy_pkg::*;

    localparam int          P_GAP    = 2;
    localparam logic [31:0] IDLE_OUT = 32'h50BC50BC;
    localparam logic [3:0]  IDLE_CHR = 4'b0101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] gt_data;
    logic [3:0]  gt_char;

    always #5 clk = ~clk;

    phy_tx_framer_if u_if ();

    phy_tx_framer #(.P_IDLE_GAP(P_GAP)) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .axis         (u_if.slave),
        .o_gt_tx_data (gt_data),
        .o_gt_tx_char (gt_char)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_d[$];
    logic [3:0]  exp_c[$];
    int          fr_words[$];
    bit          fr_exact[$];
    logic [31:0] obs_d[$];
    logic [3:0]  obs_c[$];
    int          n_frames    = 0;
    int          frames_done = 0;
    int          rdy_cnt     = 0;
    bit          mon_en      = 1'b0;
    int          rem         = 0;
    int          idle_run    = 0;
    bit          cur_exact;
    logic [31:0] ed;
    logic [3:0]  ec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Expected line stream of one frame: FB, payload, FD, zero pad to a word.
    task automatic model_frame(input logic [7:0] fb[$], input bit exact, input int stall_after);
        logic [7:0] e[$];
        bit         k[$];
        int         cnt = 0;
        e.push_back(SOF_K); k.push_back(1'b1);
        foreach (fb[i]) begin e.push_back(fb[i]); k.push_back(1'b0); end
        e.push_back(EOF_K); k.push_back(1'b1);
        while (e.size() % 4 != 0) begin e.push_back(PAD); k.push_back(1'b0); end
        for (int w = 0; w < e.size() / 4; w++) begin
            exp_d.push_back({e[4*w+3], e[4*w+2], e[4*w+1], e[4*w]});
            exp_c.push_back({k[4*w+3], k[4*w+2], k[4*w+1], k[4*w]});
            cnt++;
            if (w == stall_after) begin
                exp_d.push_back(32'h0); exp_c.push_back(4'h0); cnt++;
            end
        end
        fr_words.push_back(cnt);
        fr_exact.push_back(exact);
    endtask

    task automatic send_frame(input logic [7:0] fb[$], input bit exact, input bit hold,
                              input int stall_after, input bit zero_keep);
        int          nb = (fb.size() + 3) / 4;
        int          r;
        int          t;
        logic [31:0] d;
        logic [3:0]  kp;
        model_frame(fb, exact, stall_after);
        n_frames++;
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < 4; j++)
                d[31-8*j -: 8] = (4*b + j < fb.size()) ? fb[4*b+j] : 8'hEE;
            r  = fb.size() - 4*b;
            kp = (r >= 4) ? 4'b1111 : 4'(4'b1111 << (4 - r));
            if (b == nb - 1 && zero_keep) kp = 4'b0000;
            u_if.tdata  = d;
            u_if.tkeep  = kp;
            u_if.tlast  = (b == nb - 1);
            u_if.tvalid = 1'b1;
            t = 0;
            while (!u_if.tready && t < 200) begin @(negedge clk); t++; end
            if (!u_if.tready) begin
                n_tests++; n_fail++;
                $display("FAIL accept_timeout: ready still %b after %0d cycles, required 1", u_if.tready, t);
                u_if.tvalid = 1'b0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
            if (b == stall_after) begin
                u_if.tvalid = 1'b0;
                @(negedge clk);
            end
        end
        if (!hold) begin u_if.tvalid = 1'b0; u_if.tlast = 1'b0; end
    endtask

    task automatic wait_done();
        int t = 0;
        while (frames_done < n_frames && t < 2000) begin @(negedge clk); t++; end
        check("frames_done", 32'(frames_done), 32'(n_frames));
    endtask

    task automatic chk_obs(input string name, input logic [31:0] d, input logic [3:0] c);
        if (obs_d.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: got no observed word, required %h/%b", name, d, c);
        end else begin
            check({name, "_data"}, obs_d.pop_front(), d);
            check({name, "_char"}, 32'(obs_c.pop_front()), 32'(c));
        end
    endtask

    // Every cycle: idle between frames, expected words inside frames.
    always @(negedge clk) begin
        if (rst) begin
            rem      = 0;
            idle_run = 0;
        end else if (mon_en) begin
            if (u_if.tready) rdy_cnt++;
            if (rem == 0) begin
                if (gt_data === IDLE_OUT && gt_char === IDLE_CHR) begin
                    idle_run++;
                end else if (fr_words.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL stray_word: got %h/%b, required idle %h/%b", gt_data, gt_char, IDLE_OUT, IDLE_CHR);
                end else begin
                    rem       = fr_words.pop_front();
                    cur_exact = fr_exact.pop_front();
                    n_tests++;
                    if (cur_exact ? (idle_run != P_GAP) : (idle_run < P_GAP)) begin
                        n_fail++;
                        $display("FAIL idle_gap: got %0d idle words, required %s%0d", idle_run, cur_exact ? "" : ">=", P_GAP);
                    end
                end
            end
            if (rem > 0) begin
                ed = exp_d.pop_front();
                ec = exp_c.pop_front();
                obs_d.push_back(gt_data);
                obs_c.push_back(gt_char);
                n_tests++;
                if (gt_data !== ed || gt_char !== ec) begin
                    n_fail++;
                    $display("FAIL frame_word: got %h/%b, required %h/%b", gt_data, gt_char, ed, ec);
                end
                rem--;
                if (rem == 0) begin frames_done++; idle_run = 0; end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        int         r0;
        bit         prev_hold;
        bit         hold;
        u_if.tdata = '0; u_if.tkeep = '0; u_if.tvalid = 1'b0; u_if.tlast = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_data", gt_data, IDLE_OUT);
            check("rst_char", 32'(gt_char), 32'(IDLE_CHR));
            check("rst_ready", 32'(u_if.tready), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(u_if.tready), 32'd0);
        end

        // One full beat.
        r0 = rdy_cnt;
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(q, 1'b0, 1'b0, -1, 1'b0);
        wait_done();
        check("f1_ready_cycles", 32'(rdy_cnt - r0), 32'd1);
        chk_obs("f1_w0", 32'h332211FB, 4'b0001);
        chk_obs("f1_w1", 32'h0000FD44, 4'b0010);

        // Three beats, two bytes valid on the last.
        r0 = rdy_cnt;
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
        send_frame(q, 1'b0, 1'b0, -1, 1'b0);
        wait_done();
        check("f2_ready_cycles", 32'(rdy_cnt - r0), 32'd3);
        chk_obs("f2_w0", 32'h030201FB, 4'b0001);
        chk_obs("f2_w1", 32'h07060504, 4'b0000);
        chk_obs("f2_w2", 32'hFD0A0908, 4'b1000);

        // Five bytes then a back-to-back seven-byte frame.
        r0 = rdy_cnt;
        q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1};
        send_frame(q, 1'b0, 1'b1, -1, 1'b0);
        q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67};
        send_frame(q, 1'b1, 1'b0, -1, 1'b0);
        wait_done();
        check("f34_ready_cycles", 32'(rdy_cnt - r0), 32'd4);
        chk_obs("f3_w0", 32'hA3A2A1FB, 4'b0001);
        chk_obs("f3_w1", 32'h00FDB1A4, 4'b0100);
        chk_obs("f4_w0", 32'h636261FB, 4'b0001);
        chk_obs("f4_w1", 32'h67666564, 4'b0000);
        chk_obs("f4_w2", 32'h000000FD, 4'b0001);

        // Upstream underflow for one cycle inside a frame.
        r0 = rdy_cnt;
        q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8};
        send_frame(q, 1'b0, 1'b0, 0, 1'b0);
        wait_done();
        check("f5_ready_cycles", 32'(rdy_cnt - r0), 32'd3);
        chk_obs("f5_w0", 32'hC3C2C1FB, 4'b0001);
        chk_obs("f5_w1", 32'h00000000, 4'b0000);
        chk_obs("f5_w2", 32'hC7C6C5C4, 4'b0000);
        chk_obs("f5_w3", 32'h0000FDC8, 4'b0010);

        // keep 0000 on the last beat counts as one byte.
        q = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
        send_frame(q, 1'b0, 1'b0, -1, 1'b1);
        wait_done();
        chk_obs("f6_w0", 32'hD3D2D1FB, 4'b0001);
        chk_obs("f6_w1", 32'h00FDD5D4, 4'b0100);

        // Random frame lengths, mixing held valid and idle spacing.
        prev_hold = 1'b0;
        for (int f = 0; f < 64; f++) begin
            q = {};
            for (int i = 0; i < $urandom_range(64, 1); i++) q.push_back(8'($urandom));
            hold = ($urandom_range(1, 0) == 1);
            send_frame(q, prev_hold, hold, -1, 1'b0);
            if (!hold) repeat ($urandom_range(4, 0)) @(negedge clk);
            prev_hold = hold;
        end
        u_if.tvalid = 1'b0;
        wait_done();
        check("model_drained", 32'(exp_d.size()), 32'd0);
        obs_d.delete();
        obs_c.delete();

        // Asynchronous reset in the middle of a frame.
        mon_en = 1'b0;
        @(negedge clk);
        u_if.tdata = 32'hF1F2F3F4; u_if.tkeep = 4'b1111; u_if.tlast = 1'b0; u_if.tvalid = 1'b1;
        for (int t = 0; t < 20 && !u_if.tready; t++) @(negedge clk);
        check("mid_ready_before_rst", 32'(u_if.tready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("mid_data_before_rst", gt_data, 32'hF3F2F1FB);
        #2 rst = 1'b1;
        #1;
        check("async_rst_data", gt_data, IDLE_OUT);
        check("async_rst_char", 32'(gt_char), 32'(IDLE_CHR));
        check("async_rst_ready", 32'(u_if.tready), 32'd0);
        u_if.tvalid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        q = '{8'hE1, 8'hE2, 8'hE3};
        send_frame(q, 1'b0, 1'b0, -1, 1'b0);
        wait_done();
        chk_obs("f7_w0", 32'hE3E2E1FB, 4'b0001);
        chk_obs("f7_w1", 32'h000000FD, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
